// File: rtl/pifo_flow_queue_ctrl_if.sv
// pifo_flow_queue_ctrl_if
//   Bundles the arrival, dequeue and PIFO-side signals of the per-flow queue
//   controller.
//   Arrival : arr_valid, arr_flow_id, arr_priority -> arr_ready
//   Dequeue : deq_req -> deq_valid, deq_flow_id, deq_priority (registered)
//   PIFO    : push_valid/push_flow_id/push_priority, pifo_ready,
//             reinsert_valid/reinsert_priority, pop_valid/pop_flow_id, pop
//   slave modport  : the queue controller.
//   master modport : the traffic source, downstream consumer and PIFO.
interface pifo_flow_queue_ctrl_if #(
  parameter int FLOW_W = 5,
  parameter int PRIO_W = 8
);
  logic              arr_valid;
  logic [FLOW_W-1:0] arr_flow_id;
  logic [PRIO_W-1:0] arr_priority;
  logic              arr_ready;
  logic              deq_req;
  logic              deq_valid;
  logic [FLOW_W-1:0] deq_flow_id;
  logic [PRIO_W-1:0] deq_priority;
  logic              push_valid;
  logic [FLOW_W-1:0] push_flow_id;
  logic [PRIO_W-1:0] push_priority;
  logic              pifo_ready;
  logic              reinsert_valid;
  logic [PRIO_W-1:0] reinsert_priority;
  logic              pop_valid;
  logic [FLOW_W-1:0] pop_flow_id;
  logic              pop;

  modport slave (
    input  arr_valid, arr_flow_id, arr_priority, deq_req, pifo_ready,
           pop_valid, pop_flow_id,
    output arr_ready, deq_valid, deq_flow_id, deq_priority, push_valid,
           push_flow_id, push_priority, reinsert_valid, reinsert_priority, pop
  );

  modport master (
    output arr_valid, arr_flow_id, arr_priority, deq_req, pifo_ready,
           pop_valid, pop_flow_id,
    input  arr_ready, deq_valid, deq_flow_id, deq_priority, push_valid,
           push_flow_id, push_priority, reinsert_valid, reinsert_priority, pop
  );
endinterface

// File: rtl/pifo_flow_queue_ctrl.sv
// pifo_flow_queue_ctrl
//   Per-flow packet-rank queue manager in front of a PIFO that holds one entry
//   per backlogged flow. Arriving ranks are stored in their flow's FIFO; a flow
//   is pushed into the PIFO when it becomes backlogged; a dequeue pops the PIFO
//   head, retires that flow's head packet and, in the same cycle, reinserts
//   the flow with its next rank if it is still backlogged.
// Ports
//   clk          : clock
//   reset        : synchronous, active-high
//   bus (slave)  : arrival / dequeue / PIFO signals, see pifo_flow_queue_ctrl_if
//   stall_cycles : 16-bit saturating count of cycles where an arrival was
//                  offered but not accepted; present only when the macro
//                  PIFO_FQ_STALL_CNT_EN is defined
module pifo_flow_queue_ctrl #(
  parameter int NUM_FLOWS    = 16,
  parameter int FLOW_DEPTH   = 8,
  parameter int MAX_PRIORITY = 256,
  parameter int PRIO_WIDTH   = $clog2(MAX_PRIORITY),
  parameter int FLOW_WIDTH   = $clog2(NUM_FLOWS + 1)
) (
  input  logic clk,
  input  logic reset,
  pifo_flow_queue_ctrl_if.slave bus
`ifdef PIFO_FQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);
  localparam int IDX_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
  localparam int PTR_W = (FLOW_DEPTH > 1) ? $clog2(FLOW_DEPTH) : 1;
  localparam int CNT_W = $clog2(FLOW_DEPTH + 1);
  localparam logic [FLOW_WIDTH-1:0] FLOWS_C = FLOW_WIDTH'(NUM_FLOWS);
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FLOW_DEPTH);
  localparam logic [CNT_W-1:0]      ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0]      count  [NUM_FLOWS];
  logic [PTR_W-1:0]      rd_ptr [NUM_FLOWS];
  logic [PTR_W-1:0]      wr_ptr [NUM_FLOWS];
  logic [PRIO_WIDTH-1:0] slots  [NUM_FLOWS][FLOW_DEPTH];

  logic                  arr_in_range;
  logic [IDX_W-1:0]      f_idx, g_idx;
  logic [CNT_W-1:0]      cnt_f, cnt_g;
  logic [PTR_W-1:0]      rd_g, rd_nxt;
  logic [PRIO_WIDTH-1:0] head_prio, next_prio;
  logic                  arr_ready, accept, store, pop_fire, same_flow;
  logic [NUM_FLOWS-1:0]  inc_vec, dec_vec;

  logic                  deq_vld_p1;
  logic [FLOW_WIDTH-1:0] deq_flow_p1;
  logic [PRIO_WIDTH-1:0] deq_prio_p1;

  assign arr_in_range = bus.arr_flow_id < FLOWS_C;
  assign f_idx        = bus.arr_flow_id[IDX_W-1:0];
  assign g_idx        = bus.pop_flow_id[IDX_W-1:0];
  assign cnt_f        = arr_in_range ? count[f_idx] : '0;
  assign cnt_g        = count[g_idx];
  assign rd_g         = rd_ptr[g_idx];
  assign rd_nxt       = rd_g + 1'b1;
  assign head_prio    = slots[g_idx][rd_g];
  assign next_prio    = slots[g_idx][rd_nxt];

  // Ready depends only on stored state and the PIFO's ready, never on the
  // dequeue request, so it cannot form a loop with the downstream side.
  // Out-of-range flows are always accepted and silently dropped.
  assign arr_ready = ~reset & (~arr_in_range |
                     ((cnt_f < DEPTH_C) & ((cnt_f != '0) | bus.pifo_ready)));
  assign accept    = bus.arr_valid & arr_ready;
  assign store     = accept & arr_in_range;
  assign pop_fire  = ~reset & bus.deq_req & bus.pop_valid;
  assign same_flow = pop_fire & store & (bus.arr_flow_id == bus.pop_flow_id);

  // An arrival to the flow being popped rides on the reinsert instead of a
  // push, which keeps at most one PIFO entry per flow.
  assign bus.arr_ready         = arr_ready;
  assign bus.push_valid        = store & (cnt_f == '0) & ~same_flow;
  assign bus.push_flow_id      = bus.arr_flow_id;
  assign bus.push_priority     = bus.arr_priority;
  assign bus.pop               = pop_fire;
  assign bus.reinsert_valid    = pop_fire & ((cnt_g > ONE_C) | ((cnt_g == ONE_C) & same_flow));
  assign bus.reinsert_priority = (cnt_g > ONE_C) ? next_prio : bus.arr_priority;
  assign bus.deq_valid         = deq_vld_p1;
  assign bus.deq_flow_id       = deq_flow_p1;
  assign bus.deq_priority      = deq_prio_p1;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      inc_vec[i] = store & (bus.arr_flow_id == FLOW_WIDTH'(i));
      dec_vec[i] = pop_fire & (bus.pop_flow_id == FLOW_WIDTH'(i));
    end
  end

  // ---- stage p0 -> p1: per-flow control state and dequeue valid
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      deq_vld_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        if (inc_vec[i] & ~dec_vec[i])      count[i] <= count[i] + 1'b1;
        else if (dec_vec[i] & ~inc_vec[i]) count[i] <= count[i] - 1'b1;
        if (inc_vec[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (dec_vec[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      deq_vld_p1 <= pop_fire;
    end
  end

  // ---- stage p0 -> p1: rank storage and dequeue data
  always_ff @(posedge clk) begin
    if (store) slots[f_idx][wr_ptr[f_idx]] <= bus.arr_priority;
    if (pop_fire) begin
      deq_flow_p1 <= bus.pop_flow_id;
      deq_prio_p1 <= head_prio;
    end
  end

  pop_needs_backlog: assert property (@(posedge clk) disable iff (reset)
    pop_fire |-> (bus.pop_flow_id < FLOWS_C) && (cnt_g != '0));

`ifdef PIFO_FQ_STALL_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset)                          stall_cycles <= '0;
    else if (bus.arr_valid & ~arr_ready) stall_cycles <= sat_inc(stall_cycles);
  end
`endif
endmodule

// File: tb/tb_pifo_flow_queue_ctrl.sv
// tb_pifo_flow_queue_ctrl
//   Directed vector table, a hand-written full-flow sequence and a randomized
//   run checked against a queue-based reference model with a bench-side PIFO.
module tb_pifo_flow_queue_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pifo_flow_queue_ctrl_if #(.FLOW_W(5), .PRIO_W(8)) bus ();
`ifdef PIFO_FQ_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  pifo_flow_queue_ctrl #(.NUM_FLOWS(16), .FLOW_DEPTH(8), .MAX_PRIORITY(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIFO_FQ_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  typedef struct {
    logic rst; logic av; logic [4:0] af; logic [7:0] ap;
    logic dq; logic pr; logic pv; logic [4:0] pf;
    logic e_ready; logic e_push; logic [4:0] e_pf; logic [7:0] e_pp;
    logic e_pop; logic e_rv; logic [7:0] e_rp;
    logic e_dv; logic [4:0] e_df; logic [7:0] e_dp;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] stall_m = '0;

  // reference model: per-flow rank queues plus a PIFO of (flow, rank)
  logic [7:0] fq [16][$];
  bit         pin [16];
  logic [7:0] prk [16];
  logic       m_dv = 1'b0;
  logic [4:0] m_df = '0;
  logic [7:0] m_dp = '0;

  function automatic vec_t mk(int rst, int av, int af, int ap, int dq, int pr, int pv, int pf,
                              int er, int ep, int epf, int epp, int epop, int erv, int erp,
                              int edv, int edf, int edp);
    vec_t v;
    v.rst = rst[0]; v.av = av[0]; v.af = af[4:0]; v.ap = ap[7:0];
    v.dq = dq[0]; v.pr = pr[0]; v.pv = pv[0]; v.pf = pf[4:0];
    v.e_ready = er[0]; v.e_push = ep[0]; v.e_pf = epf[4:0]; v.e_pp = epp[7:0];
    v.e_pop = epop[0]; v.e_rv = erv[0]; v.e_rp = erp[7:0];
    v.e_dv = edv[0]; v.e_df = edf[4:0]; v.e_dp = edp[7:0];
    return v;
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset            = v.rst;
    bus.arr_valid    = v.av;
    bus.arr_flow_id  = v.af;
    bus.arr_priority = v.ap;
    bus.deq_req      = v.dq;
    bus.pifo_ready   = v.pr;
    bus.pop_valid    = v.pv;
    bus.pop_flow_id  = v.pf;
    #1;
    chk(tag, "arr_ready", 32'(bus.arr_ready), 32'(v.e_ready));
    chk(tag, "push_valid", 32'(bus.push_valid), 32'(v.e_push));
    chk(tag, "push_flow_id", 32'(bus.push_flow_id), 32'(v.e_pf));
    chk(tag, "push_priority", 32'(bus.push_priority), 32'(v.e_pp));
    chk(tag, "pop", 32'(bus.pop), 32'(v.e_pop));
    chk(tag, "reinsert_valid", 32'(bus.reinsert_valid), 32'(v.e_rv));
    if (v.e_rv) chk(tag, "reinsert_priority", 32'(bus.reinsert_priority), 32'(v.e_rp));
    chk(tag, "deq_valid", 32'(bus.deq_valid), 32'(v.e_dv));
    if (v.e_dv) begin
      chk(tag, "deq_flow_id", 32'(bus.deq_flow_id), 32'(v.e_df));
      chk(tag, "deq_priority", 32'(bus.deq_priority), 32'(v.e_dp));
    end
`ifdef PIFO_FQ_STALL_CNT_EN
    chk(tag, "stall_cycles", 32'(stall_cycles), 32'(stall_m));
`endif
    if (v.rst) stall_m = '0;
    else if (v.av && !v.e_ready && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
  endtask

  // One randomized cycle: predict outputs from the queues, apply, then advance the model.
  task automatic rnd_cycle();
    vec_t v;
    int   best, r, g, cf, cg;
    bit   fok, acc, pop, same;
    best = -1;
    for (int i = 0; i < 16; i++)
      if (pin[i] && (best < 0 || prk[i] > prk[best])) best = i;
    r = $urandom_range(0, 9);
    v.rst = ($urandom_range(0, 299) == 0);
    v.av  = ($urandom_range(0, 9) < 7);
    v.af  = (r == 0) ? 5'd16 : (r < 3) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 3));
    v.ap  = 8'($urandom_range(0, 255));
    v.dq  = ($urandom_range(0, 9) < 4);
    v.pr  = ($urandom_range(0, 7) != 0);
    v.pv  = (best >= 0);
    v.pf  = (best >= 0) ? 5'(best) : 5'd0;
    g     = (best >= 0) ? best : 0;
    fok   = (v.af < 16);
    cf    = fok ? fq[v.af].size() : 0;
    cg    = fq[g].size();
    v.e_ready = !v.rst && (!fok || (cf < 8 && (cf != 0 || v.pr)));
    acc   = v.av && v.e_ready;
    pop   = !v.rst && v.dq && v.pv;
    same  = pop && acc && fok && (int'(v.af) == g);
    v.e_push = acc && fok && cf == 0 && !same;
    v.e_pf = v.af;
    v.e_pp = v.ap;
    v.e_pop = pop;
    v.e_rv = pop && (cg > 1 || (cg == 1 && same));
    v.e_rp = (cg > 1) ? fq[g][1] : v.ap;
    v.e_dv = m_dv; v.e_df = m_df; v.e_dp = m_dp;
    apply(v, "rnd");
    if (v.rst) begin
      for (int i = 0; i < 16; i++) begin fq[i].delete(); pin[i] = 0; end
      m_dv = 1'b0;
    end else begin
      m_dv = pop;
      if (pop) begin
        m_df = 5'(g);
        m_dp = fq[g].pop_front();
        pin[g] = 0;
        if (v.e_rv) begin pin[g] = 1; prk[g] = v.e_rp; end
      end
      if (acc && fok) begin
        fq[v.af].push_back(v.ap);
        if (v.e_push) begin pin[v.af] = 1; prk[v.af] = v.ap; end
      end
    end
  endtask

  vec_t tbl [16];

  initial begin
    // rst,av,af,ap, dq,pr,pv,pf, ready,push,pf,pp, pop,rv,rp, dv,df,dp
    tbl[0]  = mk(1,0,0,0,   1,1,1,0, 0,0,0,0,    0,0,0,  0,0,0);
    tbl[1]  = mk(0,1,3,40,  0,1,0,0, 1,1,3,40,   0,0,0,  0,0,0);
    tbl[2]  = mk(0,1,3,10,  0,1,0,0, 1,0,3,10,   0,0,0,  0,0,0);
    tbl[3]  = mk(0,0,0,0,   1,1,1,3, 1,0,0,0,    1,1,10, 0,0,0);
    tbl[4]  = mk(0,0,0,0,   0,1,0,0, 1,0,0,0,    0,0,0,  1,3,40);
    tbl[5]  = mk(0,1,5,7,   0,1,0,0, 1,1,5,7,    0,0,0,  0,0,0);
    tbl[6]  = mk(0,1,5,99,  1,1,1,5, 1,0,5,99,   1,1,99, 0,0,0);
    tbl[7]  = mk(0,0,0,0,   0,1,0,0, 1,0,0,0,    0,0,0,  1,5,7);
    tbl[8]  = mk(0,1,7,33,  0,0,0,0, 0,0,7,33,   0,0,0,  0,0,0);
    tbl[9]  = mk(0,1,7,33,  0,0,0,0, 0,0,7,33,   0,0,0,  0,0,0);
    tbl[10] = mk(0,1,9,5,   0,1,0,0, 1,1,9,5,    0,0,0,  0,0,0);
    tbl[11] = mk(0,1,16,1,  0,0,0,0, 1,0,16,1,   0,0,0,  0,0,0);
    tbl[12] = mk(1,1,3,2,   1,1,1,3, 0,0,3,2,    0,0,0,  0,0,0);
    tbl[13] = mk(0,0,0,0,   0,0,0,0, 0,0,0,0,    0,0,0,  0,0,0);
    tbl[14] = mk(0,1,1,1,   0,1,0,0, 1,1,1,1,    0,0,0,  0,0,0);
    tbl[15] = mk(0,1,3,8,   0,1,0,0, 1,1,3,8,    0,0,0,  0,0,0);

    reset = 1'b1;
    bus.arr_valid = 1'b0; bus.arr_flow_id = '0; bus.arr_priority = '0;
    bus.deq_req = 1'b0; bus.pifo_ready = 1'b0; bus.pop_valid = 1'b0; bus.pop_flow_id = '0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // flow 2 fills to depth; ready drops and returns only after a dequeue of flow 2
    apply(mk(1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0), "full_rst");
    for (int i = 0; i < 8; i++)
      apply(mk(0,1,2,i+1, 0,1,0,0, 1,int'(i == 0),2,i+1, 0,0,0, 0,0,0), "full_fill");
    apply(mk(0,1,2,50, 0,1,0,0, 0,0,2,50, 0,0,0, 0,0,0), "full_block");
    apply(mk(0,1,2,50, 1,1,1,2, 0,0,2,50, 1,1,2, 0,0,0), "full_pop");
    apply(mk(0,1,2,50, 0,1,0,0, 1,0,2,50, 0,0,0, 1,2,1), "full_ready");
    apply(mk(1,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0), "rnd_rst");

    for (int i = 0; i < 16; i++) begin fq[i].delete(); pin[i] = 0; prk[i] = '0; end
    m_dv = 1'b0;
    repeat (3000) rnd_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
